lfsr_prng: RTL and testbench

Parametrised Galois LFSR pseudo-random generator, the generalised successor of the fixed 16-bit generator. It supports widths of 8, 16, 24 and 32 bits, advances a configurable number of shifts per request, and accepts a run-time seed with all-zero lock-up protection. It serves as the shared random source for test stimulus, arbitration randomisation and scrambler seeding. An optional period monitor can be compiled in.

---
 rtl/lfsr_prng.sv | 126 ++++++++++++
 tb/tb_lfsr_prng.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng.sv
// Parametrised Galois LFSR pseudo-random generator (right-shift form).
// Supports WIDTH of 8/16/24/32 with STEPS shifts unrolled per accepted advance.
// Optional period monitor compiled in with `define LFSR_PRNG_PERIOD_MON_EN; it adds a
// reference-seed register, a 32-bit advance counter and a period pulse. When the macro
// is undefined, period_o and step_cnt_o are tied to zero and no monitor logic exists.
module lfsr_prng #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned STEPS        = 1,
  parameter logic [31:0] DEFAULT_SEED = 32'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             next_i,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] rand_o,
  output logic             seed_err_o,
  output logic             period_o,
  output logic [31:0]      step_cnt_o
);

  // Maximal-length feedback masks for the supported widths.
  function automatic logic [31:0] mask_for(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]      MaskFull = mask_for(WIDTH);
  localparam logic [WIDTH-1:0] Mask     = MaskFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SeedInit = DEFAULT_SEED[WIDTH-1:0];

  // Elaboration-time parameter legality.
  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be 8, 16, 24 or 32");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_prng: STEPS must be in 1..WIDTH");
  end
  if (SeedInit == '0) begin : g_bad_seed
    $error("lfsr_prng: DEFAULT_SEED truncated to WIDTH must be non-zero");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] seed_val;
  logic             seed_zero;
  logic             seed_err_q;

  // STEPS Galois shifts applied combinationally to the current state.
  always_comb begin
    adv = state_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      adv = {1'b0, adv[WIDTH-1:1]} ^ (adv[0] ? Mask : '0);
    end
  end

  // A zero seed would lock the LFSR up, so it is replaced by the default seed.
  always_comb begin
    seed_zero = (seed_i == '0);
    seed_val  = seed_zero ? SeedInit : seed_i;
  end

  // Next state: seed load takes priority over an advance; idle holds.
  always_comb begin
    state_d = state_q;
    if (seed_valid_i) begin
      state_d = seed_val;
    end else if (next_i) begin
      state_d = adv;
    end
  end

  // State register and registered zero-seed error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SeedInit;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_err_q <= seed_valid_i & seed_zero;
    end
  end

  assign rand_o     = state_q;
  assign seed_err_o = seed_err_q;

`ifdef LFSR_PRNG_PERIOD_MON_EN
  logic [WIDTH-1:0] ref_q;
  logic [31:0]      cnt_q;
  logic             period_q;

  // Period monitor: counts advances and pulses when the state returns to the reference seed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ref_q    <= SeedInit;
      cnt_q    <= '0;
      period_q <= 1'b0;
    end else begin
      period_q <= 1'b0;
      if (seed_valid_i) begin
        ref_q <= seed_val;
        cnt_q <= '0;
      end else if (next_i) begin
        if (adv == ref_q) begin
          period_q <= 1'b1;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
    end
  end

  assign period_o   = period_q;
  assign step_cnt_o = cnt_q;
`else
  assign period_o   = 1'b0;
  assign step_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: three instances (16/1, 16/2, 8/1) share one stimulus
// stream; a reference model pushes expected outputs and a monitor pops and compares.
module tb_lfsr_prng;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        nxt = 1'b0;
  logic        sv  = 1'b0;
  logic [15:0] sd  = '0;

  always #5 clk = ~clk;

  logic [15:0] r_a, r_b;
  logic [7:0]  r_c;
  logic        e_a, e_b, e_c, p_a, p_b, p_c;
  logic [31:0] c_a, c_b, c_c;

  lfsr_prng #(.WIDTH(16), .STEPS(1), .DEFAULT_SEED(32'hACE1)) dut_a (
    .clk_i(clk), .rst_i(rst), .next_i(nxt), .seed_valid_i(sv), .seed_i(sd),
    .rand_o(r_a), .seed_err_o(e_a), .period_o(p_a), .step_cnt_o(c_a)
  );
  lfsr_prng #(.WIDTH(16), .STEPS(2), .DEFAULT_SEED(32'hACE1)) dut_b (
    .clk_i(clk), .rst_i(rst), .next_i(nxt), .seed_valid_i(sv), .seed_i(sd),
    .rand_o(r_b), .seed_err_o(e_b), .period_o(p_b), .step_cnt_o(c_b)
  );
  lfsr_prng #(.WIDTH(8), .STEPS(1), .DEFAULT_SEED(32'hACE1)) dut_c (
    .clk_i(clk), .rst_i(rst), .next_i(nxt), .seed_valid_i(sv), .seed_i(sd[7:0]),
    .rand_o(r_c), .seed_err_o(e_c), .period_o(p_c), .step_cnt_o(c_c)
  );

  typedef struct packed {
    logic [2:0][31:0] rnd;
    logic [2:0]       err;
    logic [2:0]       per;
    logic [2:0][31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bit      acc_en = 1'b0;
  longint  acc_sum = 0;
  int      acc_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 'h%0h, required 'h%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned wid(input int k);
    return (k == 2) ? 8 : 16;
  endfunction
  function automatic int unsigned stp(input int k);
    return (k == 1) ? 2 : 1;
  endfunction
  function automatic logic [31:0] wmask(input int k);
    return (wid(k) == 8) ? 32'hFF : 32'hFFFF;
  endfunction
  function automatic logic [31:0] poly(input int k);
    return (wid(k) == 8) ? 32'hB8 : 32'hB400;
  endfunction

  // n Galois shifts expressed as plain arithmetic on an integer value.
  function automatic logic [31:0] shift_n(input logic [31:0] s, input int k, input int n);
    logic [31:0] v = s;
    for (int i = 0; i < n; i++) begin
      if (v % 2 == 1) v = (v / 2) ^ poly(k);
      else            v = v / 2;
    end
    return v;
  endfunction

  logic [31:0] m_state[3];
  logic [31:0] m_ref[3];
  logic [31:0] m_cnt[3];

  // Apply one cycle of stimulus to the model and to the DUTs, queue the expectation.
  task automatic cycle(input bit r, input bit n, input bit v, input logic [15:0] s);
    exp_t e;
    @(negedge clk);
    rst = r; nxt = n; sv = v; sd = s;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] def = 32'hACE1 & wmask(k);
      logic [31:0] sk  = {16'h0, s} & wmask(k);
      logic [31:0] ns;
      e.err[k] = 1'b0;
      e.per[k] = 1'b0;
      if (r) begin
        m_state[k] = def; m_ref[k] = def; m_cnt[k] = 0;
      end else if (v) begin
        if (sk == 0) begin
          m_state[k] = def; m_ref[k] = def; e.err[k] = 1'b1;
        end else begin
          m_state[k] = sk; m_ref[k] = sk;
        end
        m_cnt[k] = 0;
      end else if (n) begin
        ns = shift_n(m_state[k], k, stp(k));
        if (ns == m_ref[k]) begin
          e.per[k] = 1'b1; m_cnt[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
        m_state[k] = ns;
      end
      e.rnd[k] = m_state[k];
`ifdef LFSR_PRNG_PERIOD_MON_EN
      e.cnt[k] = m_cnt[k];
`else
      e.per[k] = 1'b0;
      e.cnt[k] = 32'h0;
`endif
    end
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    logic [31:0] ar[3];
    logic        ae[3], ap[3];
    logic [31:0] ac[3];
    forever begin
      @(posedge clk);
      #1;
      if (acc_en) begin
        acc_sum += longint'(r_a);
        acc_n++;
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ar[0] = {16'h0, r_a}; ar[1] = {16'h0, r_b}; ar[2] = {24'h0, r_c};
        ae[0] = e_a; ae[1] = e_b; ae[2] = e_c;
        ap[0] = p_a; ap[1] = p_b; ap[2] = p_c;
        ac[0] = c_a; ac[1] = c_b; ac[2] = c_c;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("rand[%0d]", k), ar[k], e.rnd[k]);
          check($sformatf("seed_err[%0d]", k), {31'h0, ae[k]}, {31'h0, e.err[k]});
          check($sformatf("period[%0d]", k), {31'h0, ap[k]}, {31'h0, e.per[k]});
          check($sformatf("step_cnt[%0d]", k), ac[k], e.cnt[k]);
          check($sformatf("rand_nonzero[%0d]", k), {31'h0, (ar[k] != 0)}, 32'h1);
        end
      end
    end
  end

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset and the documented first sequence.
    cycle(1, 0, 0, 16'h0);
    settle();
    check("reset_rand_a", {16'h0, r_a}, 32'hACE1);
    check("reset_rand_c", {24'h0, r_c}, 32'hE1);
    check("reset_err_a", {31'h0, e_a}, 32'h0);
    cycle(0, 1, 0, 16'h0);
    settle();
    check("first_next_a", {16'h0, r_a}, 32'hE270);
    check("steps2_next_b", {16'h0, r_b}, 32'h7138);
    cycle(0, 1, 0, 16'h0);
    settle();
    check("second_next_a", {16'h0, r_a}, 32'h7138);

    // Zero seed is replaced and flagged for one cycle.
    cycle(0, 1, 1, 16'h0);
    settle();
    check("zero_seed_rand_a", {16'h0, r_a}, 32'hACE1);
    check("zero_seed_err_a", {31'h0, e_a}, 32'h1);
    cycle(0, 0, 0, 16'h0);
    settle();
    check("zero_seed_err_drop_a", {31'h0, e_a}, 32'h0);
    check("idle_hold_a", {16'h0, r_a}, 32'hACE1);

    // Seed load with a simultaneous advance loads only.
    cycle(0, 1, 1, 16'h1234);
    settle();
    check("seed_with_next_a", {16'h0, r_a}, 32'h1234);
    check("seed_with_next_c", {24'h0, r_c}, 32'h34);

    // Full 8-bit period from reset.
    cycle(1, 0, 0, 16'h0);
    for (int i = 0; i < 255; i++) cycle(0, 1, 0, 16'h0);
    settle();
    check("period_rand_c", {24'h0, r_c}, 32'hE1);
`ifdef LFSR_PRNG_PERIOD_MON_EN
    check("period_pulse_c", {31'h0, p_c}, 32'h1);
`else
    check("period_tied_c", {31'h0, p_c}, 32'h0);
`endif
    check("period_cnt_c", c_c, 32'h0);

    // Randomised mix of reset, seed loads (including zero seeds) and advances.
    for (int i = 0; i < 400; i++) begin
      bit r = ($urandom_range(0, 49) == 0);
      bit v = ($urandom_range(0, 7) == 0);
      bit n = ($urandom_range(0, 3) != 0);
      logic [15:0] s;
      case ($urandom_range(0, 3))
        0:       s = 16'h0;
        1:       s = {8'($urandom), 8'h00};
        default: s = 16'($urandom);
      endcase
      cycle(r, n, v, s);
    end

    // Mean of 10000 consecutive samples from reset.
    cycle(1, 0, 0, 16'h0);
    settle();
    acc_en = 1'b1;
    for (int i = 0; i < 10000; i++) cycle(0, 1, 0, 16'h0);
    settle();
    acc_en = 1'b0;
    check("mean_low", {31'h0, (acc_sum * 10 > longint'(4) * 65536 * acc_n)}, 32'h1);
    check("mean_high", {31'h0, (acc_sum * 10 < longint'(6) * 65536 * acc_n)}, 32'h1);

    // Mid-run reset restarts the sequence.
    for (int i = 0; i < 3000; i++) cycle(0, 1, 0, 16'h0);
    cycle(1, 1, 1, 16'h5555);
    settle();
    check("midrun_reset_a", {16'h0, r_a}, 32'hACE1);
    check("midrun_reset_cnt_a", c_a, 32'h0);
    for (int i = 0; i < 50; i++) cycle(0, 1, 0, 16'h0);

    cycle(0, 0, 0, 16'h0);
    settle();
    settle();
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
